// File: rtl/clock_div_ctrl_pkg.sv
// Shared definitions for the clock divider change controller:
// FSM state encoding, requester indices and the illegal divider code.
package clock_div_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_idx_t;

  // Divider code 1 makes clock_div output stuck low, so it is never applied.
  localparam int N_ILLEGAL = 1;

endpackage

// File: rtl/clock_div_ctrl_arb.sv
// Two-way round-robin arbiter. Grant is a one-hot decode of the valids;
// on contention the pointer picks the winner. Whenever a grant is taken
// (advance high) the pointer moves to the requester that did not win.
module clock_div_ctrl_arb
  import clock_div_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       resetb,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  req_idx_t ptr_reg;

  // Combinational grant: single requester wins outright, pointer breaks ties.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (ptr_reg == REQ_A) ? 2'b01 : 2'b10;
    end
  end

  // Pointer update: favour the other requester after every taken grant.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      ptr_reg <= REQ_A;
    end else if (advance && (grant != 2'b00)) begin
      ptr_reg <= grant[0] ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/clock_div_ctrl.sv
// Clock divider change controller. Arbitrates N-change requests from two
// masters, rejects the stuck-low code, applies legal values to div_n and
// holds the acknowledge until the divider has had time to resynchronise.
// Optional feature: define CLK_DIV_CTRL_LOCK_EN to add lock_req/locked,
// a sticky lock that makes every later request complete with err=1.
module clock_div_ctrl
  import clock_div_ctrl_pkg::*;
#(
  parameter int SIZE          = 3,
  parameter int DEFAULT_N     = 2,
  parameter int SETTLE_CYCLES = 24
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            a_valid,
  input  logic [SIZE-1:0] a_n,
  output logic            a_ack,
  input  logic            b_valid,
  input  logic [SIZE-1:0] b_n,
  output logic            b_ack,
  output logic            err,
  output logic [SIZE-1:0] div_n,
  output logic            busy
`ifdef CLK_DIV_CTRL_LOCK_EN
  ,
  input  logic            lock_req,
  output logic            locked
`endif
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [SIZE-1:0] div_n_reg, div_n_next;
  req_idx_t        grantee_reg, grantee_next;
  logic            a_ack_reg, a_ack_next;
  logic            b_ack_reg, b_ack_next;
  logic            err_reg, err_next;
  logic            busy_reg, busy_next;

  logic [1:0]      grant;
  logic            advance;
  req_idx_t        grant_idx;
  logic [SIZE-1:0] n_sel;
  logic            reject;
  logic            locked_reg;

  clock_div_ctrl_arb u_arb (
    .clk     (clk),
    .resetb  (resetb),
    .valid   ({b_valid, a_valid}),
    .advance (advance),
    .grant   (grant)
  );

`ifdef CLK_DIV_CTRL_LOCK_EN
  // Sticky lock: set only by an idle cycle in which nothing was granted.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      locked_reg <= 1'b0;
    end else if ((state_reg == ST_IDLE) && (grant == 2'b00) && lock_req) begin
      locked_reg <= 1'b1;
    end
  end
  assign locked = locked_reg;
`else
  assign locked_reg = 1'b0;
`endif

  // Next-state and next-output logic for the IDLE/SETTLE/ACK sequencer.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    div_n_next   = div_n_reg;
    grantee_next = grantee_reg;
    a_ack_next   = 1'b0;
    b_ack_next   = 1'b0;
    err_next     = 1'b0;
    advance      = 1'b0;

    grant_idx = grant[1] ? REQ_B : REQ_A;
    n_sel     = (grant_idx == REQ_B) ? b_n : a_n;
    reject    = locked_reg || (n_sel == SIZE'(N_ILLEGAL));

    case (state_reg)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          advance      = 1'b1;
          grantee_next = grant_idx;
          if (reject || (n_sel == div_n_reg)) begin
            // Nothing to apply: acknowledge on the next cycle.
            a_ack_next = (grant_idx == REQ_A);
            b_ack_next = (grant_idx == REQ_B);
            err_next   = reject;
            state_next = ST_ACK;
          end else begin
            div_n_next = n_sel;
            cnt_next   = CW'(SETTLE_CYCLES - 1);
            state_next = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CW'(1);
        end else begin
          a_ack_next = (grantee_reg == REQ_A);
          b_ack_next = (grantee_reg == REQ_B);
          state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      div_n_reg   <= SIZE'(DEFAULT_N);
      grantee_reg <= REQ_A;
      a_ack_reg   <= 1'b0;
      b_ack_reg   <= 1'b0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      div_n_reg   <= div_n_next;
      grantee_reg <= grantee_next;
      a_ack_reg   <= a_ack_next;
      b_ack_reg   <= b_ack_next;
      err_reg     <= err_next;
      busy_reg    <= busy_next;
    end
  end

  assign a_ack = a_ack_reg;
  assign b_ack = b_ack_reg;
  assign err   = err_reg;
  assign div_n = div_n_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Self-checking bench for clock_div_ctrl. Expected timelines are built
// per transaction from the request rules (round-robin order, reject /
// no-change / settle latency) and compared every cycle on the falling edge.
module tb_clock_div_ctrl;

  localparam int SIZE   = 3;
  localparam int DEF_N  = 2;
  localparam int SETTLE = 24;
  localparam int TL     = 128;

  logic            clk;
  logic            resetb;
  logic            a_valid;
  logic [SIZE-1:0] a_n;
  logic            a_ack;
  logic            b_valid;
  logic [SIZE-1:0] b_n;
  logic            b_ack;
  logic            err;
  logic [SIZE-1:0] div_n;
  logic            busy;
`ifdef CLK_DIV_CTRL_LOCK_EN
  logic            lock_req;
  logic            locked;
`endif

  clock_div_ctrl dut (
    .clk     (clk),
    .resetb  (resetb),
    .a_valid (a_valid),
    .a_n     (a_n),
    .a_ack   (a_ack),
    .b_valid (b_valid),
    .b_n     (b_n),
    .b_ack   (b_ack),
    .err     (err),
    .div_n   (div_n),
    .busy    (busy)
`ifdef CLK_DIV_CTRL_LOCK_EN
    ,
    .lock_req(lock_req),
    .locked  (locked)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int m_div;
  int m_ptr;     // 0: A favoured on contention, 1: B favoured
  int m_locked;

  // Expected per-cycle timeline for the current transaction
  int e_aack [TL];
  int e_back [TL];
  int e_err  [TL];
  int e_div  [TL];
  int e_busy [TL];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_div    = DEF_N;
    m_ptr    = 0;
    m_locked = 0;
  endtask

  task automatic check_outputs(input string where, input int xa, input int xb, input int xe,
                               input int xd, input int xbusy);
    chk({where, " a_ack"}, 32'(a_ack), 32'(xa));
    chk({where, " b_ack"}, 32'(b_ack), 32'(xb));
    chk({where, " err"},   32'(err),   32'(xe));
    chk({where, " div_n"}, 32'(div_n), 32'(xd));
    chk({where, " busy"},  32'(busy),  32'(xbusy));
`ifdef CLK_DIV_CTRL_LOCK_EN
    chk({where, " locked"}, 32'(locked), 32'(m_locked));
`endif
  endtask

  // Quiet cycles: no acks, nothing busy, divider holds its value.
  task automatic idle_cycles(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_outputs($sformatf("%s c%0d", name, i), 0, 0, 0, m_div, 0);
    end
    $display("txn %s: %0d idle cycles, div_n=%0d", name, n, m_div);
  endtask

  // Random N biased toward the interesting codes (illegal and unchanged).
  function automatic int pick_n();
    int r;
    r = int'($urandom_range(0, 3));
    if (r == 0) return 1;
    if (r == 1) return m_div;
    return int'($urandom_range(0, 7));
  endfunction

  // Issue one or two simultaneous requests; caller is on a falling edge.
  task automatic run_txn(input bit ra, input bit rb, input int na, input int nb);
    int order[$];
    int s, ack_k, g, n, last;
    bit rej, quick;
    string tag;

    for (int k = 0; k < TL; k++) begin
      e_aack[k] = 0; e_back[k] = 0; e_err[k] = 0; e_busy[k] = 0; e_div[k] = m_div;
    end
    if (ra && rb) begin
      order.push_back(m_ptr);
      order.push_back(1 - m_ptr);
    end else if (ra) begin
      order.push_back(0);
    end else begin
      order.push_back(1);
    end

    // s is the rising edge on which a grant is taken from IDLE
    s = 1;
    foreach (order[i]) begin
      g     = order[i];
      n     = (g == 1) ? nb : na;
      rej   = (m_locked != 0) || (n == 1);
      quick = rej || (n == m_div);
      ack_k = quick ? s : s + SETTLE;
      for (int k = s; k <= ack_k; k++) e_busy[k] = 1;
      if (g == 0) e_aack[ack_k] = 1; else e_back[ack_k] = 1;
      e_err[ack_k] = rej ? 1 : 0;
      if (!quick) begin
        m_div = n;
        for (int k = s; k < TL; k++) e_div[k] = n;
      end
      m_ptr = 1 - g;
      s = ack_k + 2;
    end
    last = s;

    a_valid = ra;
    a_n     = SIZE'(na);
    b_valid = rb;
    b_n     = SIZE'(nb);
    tag = $sformatf("txn A%0d:%0d B%0d:%0d", ra, na, rb, nb);
    for (int k = 1; k <= last; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_outputs($sformatf("%s k%0d", tag, k), e_aack[k], e_back[k], e_err[k], e_div[k], e_busy[k]);
      if (e_aack[k] != 0) a_valid = 1'b0;
      if (e_back[k] != 0) b_valid = 1'b0;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    $display("%s -> div_n=%0d over %0d cycles", tag, m_div, last);
  endtask

  // Reset asserted ten cycles into a settle: everything returns to reset values at once.
  task automatic reset_mid_settle();
    if (m_div == 7) run_txn(1'b1, 1'b0, 3, 0);
    a_valid = 1'b1;
    a_n     = SIZE'(7);
    repeat (11) @(posedge clk);
    #2;
    resetb = 1'b0;
    #1;
    check_outputs("rst_mid", 0, 0, 0, DEF_N, 0);
    a_valid = 1'b0;
    @(negedge clk);
    model_reset();
    check_outputs("rst_hold", 0, 0, 0, m_div, 0);
    resetb = 1'b1;
    $display("txn reset mid-settle after A N=7 -> div_n=%0d", m_div);
    idle_cycles(30, "post_rst");
  endtask

  initial begin
    resetb  = 1'b0;
    a_valid = 1'b0;
    a_n     = '0;
    b_valid = 1'b0;
    b_n     = '0;
`ifdef CLK_DIV_CTRL_LOCK_EN
    lock_req = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset", 0, 0, 0, DEF_N, 0);
    resetb = 1'b1;

    idle_cycles(100, "idle");
    run_txn(1'b1, 1'b0, 5, 0);
    reset_mid_settle();
    run_txn(1'b1, 1'b1, 4, 6);
    run_txn(1'b1, 1'b1, 4, 6);
    chk("final div after pairs", 32'(div_n), 32'd6);
    run_txn(1'b0, 1'b1, 1, 0);
    run_txn(1'b0, 1'b1, 0, m_div);
    run_txn(1'b1, 1'b0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      int sel;
      int na;
      int nb;
      sel = int'($urandom_range(0, 2));
      na  = pick_n();
      nb  = pick_n();
      run_txn(sel != 1, sel != 0, na, nb);
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 4)), "gap");
    end

`ifdef CLK_DIV_CTRL_LOCK_EN
    lock_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lock_req = 1'b0;
    m_locked = 1;
    check_outputs("lock_set", 0, 0, 0, m_div, 0);
    $display("txn lock_req pulse -> locked=%0d", locked);
    run_txn(1'b1, 1'b0, 3, 0);
    for (int t = 0; t < 4; t++) run_txn(1'b1, 1'b1, pick_n(), pick_n());
    resetb = 1'b0;
    #1;
    model_reset();
    check_outputs("lock_clear", 0, 0, 0, m_div, 0);
    @(negedge clk);
    resetb = 1'b1;
    $display("txn reset clears lock -> locked=%0d", locked);
    run_txn(1'b1, 1'b0, 3, 0);
`endif

    idle_cycles(5, "tail");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
